// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-array signals around the shared memory port arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_misalign;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-2:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, d_misalign,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, d_misalign,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port word memory between instruction fetch and LW/SW data accesses,
// data first, with a bounded guard so a pending fetch wins after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);
  localparam logic [LatW-1:0] LatLast   = LatW'(MEM_LAT - 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;   // 1 = data port, 0 = fetch port
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LatW-1:0]   lat_q, lat_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic data_win;
  logic lat_last;

  assign data_win = bus.d_req && (!bus.if_req || (starve_q != StarveMax));
  assign lat_last = (lat_q == LatLast);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.d_req || bus.if_req) begin
          owner_d = data_win;
          lat_d   = '0;
          if (data_win) begin
            addr_d  = bus.d_addr;
            we_d    = bus.d_we;
            wdata_d = bus.d_wdata;
            if (!bus.if_req) begin
              starve_d = '0;
            end else if (starve_q != StarveMax) begin
              starve_d = starve_q + 1'b1;
            end
            // A misaligned data access skips the memory cycle entirely.
            state_d = bus.d_addr[0] ? StResp : StAccess;
          end else begin
            addr_d   = bus.if_addr;
            we_d     = 1'b0;
            starve_d = '0;
            state_d  = StAccess;
          end
        end
      end
      StAccess: begin
        if (lat_last) begin
          state_d = StResp;
          if (!we_q) begin
            if (owner_q) begin
              d_rdata_d = bus.mem_rdata;
            end else begin
              if_rdata_d = bus.mem_rdata;
            end
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      lat_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign bus.mem_en     = (state_q == StAccess);
  // Single write commit on the last access cycle only.
  assign bus.mem_we     = (state_q == StAccess) && lat_last && owner_q && we_q;
  assign bus.mem_addr   = addr_q[ADDR_W-1:1];
  assign bus.mem_wdata  = wdata_q;
  assign bus.if_ack     = (state_q == StResp) && !owner_q;
  assign bus.d_ack      = (state_q == StResp) && owner_q;
  assign bus.d_misalign = (state_q == StResp) && owner_q && addr_q[0];
  assign bus.busy       = (state_q != StIdle);
  assign bus.if_rdata   = if_rdata_q;
  assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a fixed-latency word memory model.
module tb_mem_port_arbiter;

  localparam int unsigned MemLat = 2;

  logic clk;
  logic rst;
  logic load;
  int   n_tests;
  int   n_fail;
  int   en_cnt;
  logic [15:0] mem [256];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .MEM_LAT   (MemLat),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is only valid on the final access cycle; garbage otherwise.
  assign bus.mem_rdata = (bus.mem_en && en_cnt == int'(MemLat) - 1) ?
                         mem[bus.mem_addr[7:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) begin
        mem[i] <= (i == 11) ? 16'h6704 : (i == 18) ? 16'h5A5A : (16'hA000 | 16'(i));
      end
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
    en_cnt <= bus.mem_en ? en_cnt + 1 : 0;
  end

  task automatic test_reset();
    logic [68:0] outs;
    repeat (2) @(negedge clk);
    load = 1'b0;
    outs = {bus.if_rdata, bus.if_ack, bus.d_rdata, bus.d_ack, bus.d_misalign, bus.mem_en,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {bus.if_rdata, bus.if_ack, bus.d_rdata, bus.d_ack, bus.d_misalign, bus.mem_en,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got %h, want 0", outs);
    end
  endtask

  task automatic test_fetch();
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0016;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.mem_en !== (k <= 2) || bus.mem_we !== 1'b0 ||
          (k <= 2 && bus.mem_addr !== 15'h000B)) begin
        n_fail++;
        $display("FAIL fetch_mem T+%0d: mem_en=%b mem_we=%b mem_addr=%h, want mem_en=%b addr 000b",
                 k, bus.mem_en, bus.mem_we, bus.mem_addr, (k <= 2));
      end
      n_tests++;
      if (bus.if_ack !== (k == 3) || bus.d_ack !== 1'b0 || bus.busy !== (k <= 3)) begin
        n_fail++;
        $display("FAIL fetch_ack T+%0d: if_ack=%b d_ack=%b busy=%b, want if_ack=%b busy=%b",
                 k, bus.if_ack, bus.d_ack, bus.busy, (k == 3), (k <= 3));
      end
      if (k == 3) begin
        n_tests++;
        if (bus.if_rdata !== 16'h6704) begin
          n_fail++;
          $display("FAIL fetch_rdata: got %h, want 6704", bus.if_rdata);
        end
        bus.if_req = 1'b0;
      end
    end
    n_tests++;
    if (bus.if_rdata !== 16'h6704) begin
      n_fail++;
      $display("FAIL fetch_rdata_hold: got %h, want 6704", bus.if_rdata);
    end
  endtask

  task automatic test_load();
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 16'h0024;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.d_ack !== (k == 3) || bus.if_ack !== 1'b0 || bus.d_misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL load_ack T+%0d: d_ack=%b if_ack=%b d_misalign=%b, want d_ack=%b",
                 k, bus.d_ack, bus.if_ack, bus.d_misalign, (k == 3));
      end
      if (k == 3) begin
        n_tests++;
        if (bus.d_rdata !== 16'h5A5A) begin
          n_fail++;
          $display("FAIL load_rdata: got %h, want 5a5a", bus.d_rdata);
        end
        bus.d_req = 1'b0;
      end
    end
  endtask

  task automatic test_store();
    int we_cnt;
    we_cnt = 0;
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h002A;
    bus.d_wdata = 16'h1234;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) we_cnt++;
      if (k == 2) begin
        n_tests++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 15'h0015 || bus.mem_wdata !== 16'h1234) begin
          n_fail++;
          $display("FAIL store_write: mem_we=%b addr=%h wdata=%h, want 1 0015 1234",
                   bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
      end
      if (k == 3) begin
        n_tests++;
        if (bus.d_ack !== 1'b1 || bus.d_rdata !== 16'h5A5A) begin
          n_fail++;
          $display("FAIL store_ack: d_ack=%b d_rdata=%h, want 1 5a5a", bus.d_ack, bus.d_rdata);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
    end
    n_tests++;
    if (we_cnt != 1) begin
      n_fail++;
      $display("FAIL store_we_count: got %0d, want 1", we_cnt);
    end
    bus.d_req = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.d_ack !== 1'b1 || bus.d_rdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL store_readback: d_ack=%b d_rdata=%h, want 1 1234", bus.d_ack, bus.d_rdata);
    end
    bus.d_req = 1'b0;
  endtask

  task automatic test_starve();
    string exp;
    byte   got_c;
    int    got;
    logic  prev_ack;
    exp      = "DDDDFDDDDF";
    got      = 0;
    prev_ack = 1'b0;
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0016;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 16'h0024;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clk);
      if (bus.d_ack === 1'b1 || bus.if_ack === 1'b1) begin
        got_c = (bus.d_ack === 1'b1 && bus.if_ack !== 1'b1) ? "D" :
                (bus.if_ack === 1'b1 && bus.d_ack !== 1'b1) ? "F" : "?";
        n_tests++;
        if (got_c != exp[got] || prev_ack) begin
          n_fail++;
          $display("FAIL starve_grant %0d: got %s (prev_ack=%b), want %s",
                   got, string'(got_c), prev_ack, string'(exp[got]));
        end
        got++;
        if (got == 10) begin
          bus.if_req = 1'b0;
          bus.d_req  = 1'b0;
        end
      end
      prev_ack = bus.d_ack | bus.if_ack;
    end
    n_tests++;
    if (got != 10) begin
      n_fail++;
      $display("FAIL starve_timeout: got %0d grants, want 10", got);
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0025;
    bus.d_wdata = 16'hBEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      n_tests++;
      if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.d_ack !== (k == 1) ||
          bus.d_misalign !== (k == 1) || bus.busy !== (k == 1)) begin
        n_fail++;
        $display("FAIL misalign T+%0d: en=%b we=%b ack=%b mis=%b busy=%b, want 0 0 %b %b %b",
                 k, bus.mem_en, bus.mem_we, bus.d_ack, bus.d_misalign, bus.busy,
                 (k == 1), (k == 1), (k == 1));
      end
      if (k == 1) begin
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
    end
    n_tests++;
    if (bus.d_rdata !== 16'h5A5A || mem[8'h12] !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL misalign_nochange: d_rdata=%h mem[12]=%h, want 5a5a 5a5a",
               bus.d_rdata, mem[8'h12]);
    end
  endtask

  task automatic test_reset_mid();
    logic [68:0] outs;
    int we_cnt;
    we_cnt = 0;
    @(negedge clk);
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h002E;
    bus.d_wdata = 16'hC0DE;
    @(negedge clk);
    n_tests++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_access: mem_en=%b mem_we=%b, want 1 0", bus.mem_en, bus.mem_we);
    end
    rst = 1'b0;
    #1;
    outs = {bus.if_rdata, bus.if_ack, bus.d_rdata, bus.d_ack, bus.d_misalign, bus.mem_en,
            bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %h, want 0", outs);
    end
    @(negedge clk);
    n_tests++;
    if (bus.mem_we !== 1'b0 || bus.d_ack !== 1'b0 || mem[8'h17] !== 16'hA017) begin
      n_fail++;
      $display("FAIL rstmid_nocommit: mem_we=%b d_ack=%b mem[17]=%h, want 0 0 a017",
               bus.mem_we, bus.d_ack, mem[8'h17]);
    end
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.mem_we === 1'b1) we_cnt++;
      n_tests++;
      if (bus.mem_we !== (k == 2) || bus.d_ack !== (k == 3)) begin
        n_fail++;
        $display("FAIL rstmid_restart T+%0d: mem_we=%b d_ack=%b, want %b %b",
                 k, bus.mem_we, bus.d_ack, (k == 2), (k == 3));
      end
      if (k == 3) begin
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
      end
    end
    n_tests++;
    if (we_cnt != 1 || mem[8'h17] !== 16'hC0DE) begin
      n_fail++;
      $display("FAIL rstmid_commit: writes=%0d mem[17]=%h, want 1 c0de", we_cnt, mem[8'h17]);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b0;
    load        = 1'b1;
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_starve();
    test_misalign();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port 16-bit word memory between the instruction-fetch requester and the data requester (LW/SW). It grants one requester at a time, sequences a fixed-latency memory access, and returns read data with a one-cycle acknowledge. Data accesses have priority over fetches, and a bounded starvation guard ensures fetches still make progress. It sits between the fetch stage, the memory stage and the unified memory array.

## Interface
- ADDR_W, 16, byte-address width; memory word address is ADDR_W-1 bits.
- DATA_W, 16, instruction/data word width.
- MEM_LAT, 2, memory read latency in cycles; must be >= 1.
- STARVE_MAX, 4, maximum number of consecutive data grants while a fetch is pending.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level; held until if_ack.
- if_addr  in  ADDR_W  fetch byte address (PC); bit 0 is ignored.
- if_rdata  out  DATA_W  fetched instruction, valid while if_ack is high and held afterwards.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request, level; held until d_ack.
- d_we  in  1  1 = store (SW), 0 = load (LW).
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_ack.
- d_ack  out  1  one-cycle data completion pulse.
- d_misalign  out  1  pulses together with d_ack when d_addr[0] = 1.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W-1  word address, equal to the latched byte address [ADDR_W-1:1].
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after mem_en rises.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE: arbitration.**
  - If only one requester is active, grant it.
  - If both are active, grant data, unless starve_cnt == STARVE_MAX, in which case grant fetch.
  - On a grant, latch the owner, address, we and wdata.
  - Go to ACCESS, or go straight to RESP for a misaligned data access.
- **ACCESS:** lasts exactly MEM_LAT cycles, counted by a latency counter.
  - mem_en is high for all of these cycles; mem_addr and mem_wdata come from the latched values.
  - mem_we is high only on the final ACCESS cycle, and only for a data store. This gives exactly one write commit.
  - On the final cycle, a read captures mem_rdata into the owner's rdata register.
  - Next state is RESP.
- **RESP:** pulse the owner's ack for one cycle, then go to IDLE.
  - No arbitration happens in RESP, because the requester's req is still high during its ack cycle.
- **Misaligned data address** (d_addr[0] = 1):
  - No memory cycle is issued, so mem_en is never asserted.
  - IDLE goes directly to RESP; d_ack and d_misalign pulse together.
  - d_rdata is unchanged and nothing is written.
- **Fetch address bit 0** is dropped silently; a fetch is never flagged misaligned.
- **starve_cnt** (width clog2(STARVE_MAX+1)):
  - Increments on a data grant while if_req = 1.
  - Clears on any fetch grant.
  - Clears on a data grant while if_req = 0.
  - Saturates at STARVE_MAX.
- **Stores:** d_rdata is unchanged.
- **rdata registers:** if_rdata and d_rdata each hold their last value until overwritten by a later read of the same port.

## Timing
- Reset values: all outputs 0, FSM in IDLE, latency counter 0, starve_cnt 0, rdata registers 0.
- Reset asserted mid-access:
  - The in-flight access is abandoned and no ack is issued.
  - A store whose final ACCESS cycle has not yet been reached is not committed.
  - After reset releases, requesters that are still holding req are re-arbitrated from IDLE.
- Latency for a request seen in IDLE at cycle T:
  - ACCESS occupies cycles T+1 .. T+MEM_LAT.
  - ack is high in cycle T+MEM_LAT+1.
  - IDLE is re-entered at T+MEM_LAT+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Misaligned data access: ack arrives at T+1.
- A requester may raise req in any cycle and must hold req and its inputs stable until ack. It drops req, or presents a new request, in the cycle after ack.
- Simultaneous new requests in IDLE are resolved by the priority rule above. The loser's req stays pending and is not lost.

## Test plan
- **Reset defaults, fetch read, data load** (MEM_LAT=2, memory word 0x000B = 16'h6704):
  - After rst, check all outputs 0 and busy = 0.
  - Fetch read: if_addr = 16'h0016 asserted at cycle T -> mem_en at T+1 and T+2 with mem_addr = 15'h000B; if_ack at T+3 with if_rdata = 16'h6704; busy low at T+4.
  - Data load: LW at d_addr = 16'h0024 -> d_rdata equals the memory word at 0x0012; d_ack at T+3; if_ack stays 0.
- **Store:** SW with d_addr = 16'h002A, d_wdata = 16'h1234 -> mem_we is high for exactly one cycle (T+2) with mem_addr = 15'h0015; a following LW from 0x002A returns 16'h1234.
- **Priority and starvation** (STARVE_MAX=4): hold if_req and d_req high continuously -> grant sequence is D, D, D, D, F, D, D, D, D, F; each ack is a single pulse.
- **Misaligned store:** d_addr = 16'h0025 with d_we = 1 -> d_ack and d_misalign high at T+1; mem_en and mem_we never assert; the memory word at 0x0012 is unchanged.
- **Reset mid-access:** assert rst during the first ACCESS cycle of a store -> no mem_we pulse, no ack, all outputs 0. Release rst with d_req still high -> the access restarts and completes normally with a single write.
